// File: rtl/id_ex_reg_r0.sv
// ID/EX pipeline register. Handles load-use bubble insertion, branch flush,
// downstream hold, and a saturating load-use stall counter.
module id_ex_reg_r0 #(
    parameter int unsigned ALUOP_WIDTH    = 6,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        id_valid_i,
    input  logic [ALUOP_WIDTH+8:0]      id_ctrl_i,
    input  logic                        id_jal_i,
    input  logic                        id_eq_i,
    input  logic                        id_mem_signed_i,
    input  logic [1:0]                  id_mem_size_i,
    input  logic [DATA_WIDTH-1:0]       id_pc4_i,
    input  logic [DATA_WIDTH-1:0]       id_rs_data_i,
    input  logic [DATA_WIDTH-1:0]       id_rt_data_i,
    input  logic [DATA_WIDTH-1:0]       id_imm_i,
    input  logic [REG_ADDR_WIDTH-1:0]   id_rs_i,
    input  logic [REG_ADDR_WIDTH-1:0]   id_rt_i,
    input  logic [REG_ADDR_WIDTH-1:0]   id_rd_i,
    input  logic                        flush_i,
    input  logic                        ex_hold_i,
    output logic                        ex_valid_o,
    output logic [ALUOP_WIDTH+8:0]      ex_ctrl_o,
    output logic                        ex_jal_o,
    output logic                        ex_eq_o,
    output logic                        ex_mem_signed_o,
    output logic [1:0]                  ex_mem_size_o,
    output logic [DATA_WIDTH-1:0]       ex_pc4_o,
    output logic [DATA_WIDTH-1:0]       ex_rs_data_o,
    output logic [DATA_WIDTH-1:0]       ex_rt_data_o,
    output logic [DATA_WIDTH-1:0]       ex_imm_o,
    output logic [REG_ADDR_WIDTH-1:0]   ex_rs_o,
    output logic [REG_ADDR_WIDTH-1:0]   ex_rt_o,
    output logic [REG_ADDR_WIDTH-1:0]   ex_rd_o,
    output logic                        hazard_stall_c_o,
    output logic [CNT_WIDTH-1:0]        stall_cnt_o
);

    localparam int unsigned CTRL_W       = ALUOP_WIDTH + 9;
    localparam int unsigned BIT_MEMWRITE = 0;
    localparam int unsigned BIT_MEMREAD  = 1;
    localparam int unsigned BIT_JUMP     = 3;
    localparam int unsigned BIT_ALUSRC   = 4;

    logic                      valid_q,      valid_d;
    logic [CTRL_W-1:0]         ctrl_q,       ctrl_d;
    logic                      jal_q,        jal_d;
    logic                      eq_q,         eq_d;
    logic                      mem_signed_q, mem_signed_d;
    logic [1:0]                mem_size_q,   mem_size_d;
    logic [DATA_WIDTH-1:0]     pc4_q,        pc4_d;
    logic [DATA_WIDTH-1:0]     rs_data_q,    rs_data_d;
    logic [DATA_WIDTH-1:0]     rt_data_q,    rt_data_d;
    logic [DATA_WIDTH-1:0]     imm_q,        imm_d;
    logic [REG_ADDR_WIDTH-1:0] rs_q,         rs_d;
    logic [REG_ADDR_WIDTH-1:0] rt_q,         rt_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q,         rd_d;
    logic [CNT_WIDTH-1:0]      stall_cnt_q,  stall_cnt_d;
    logic                      load_use_c;

    // Load in EX whose destination is a source the ID instruction actually reads.
    always_comb begin
        load_use_c = valid_q & ctrl_q[BIT_MEMREAD] & (rt_q != '0) & id_valid_i &
                     ((~id_ctrl_i[BIT_JUMP] & (id_rs_i == rt_q)) |
                      ((~id_ctrl_i[BIT_ALUSRC] | id_ctrl_i[BIT_MEMWRITE]) & (id_rt_i == rt_q)));
        hazard_stall_c_o = ~flush_i & (ex_hold_i | load_use_c);
    end

    always_comb begin
        valid_d      = valid_q;
        ctrl_d       = ctrl_q;
        jal_d        = jal_q;
        eq_d         = eq_q;
        mem_signed_d = mem_signed_q;
        mem_size_d   = mem_size_q;
        pc4_d        = pc4_q;
        rs_data_d    = rs_data_q;
        rt_data_d    = rt_data_q;
        imm_d        = imm_q;
        rs_d         = rs_q;
        rt_d         = rt_q;
        rd_d         = rd_q;
        stall_cnt_d  = stall_cnt_q;
        if (flush_i || (!ex_hold_i && load_use_c)) begin
            // Bubble: kill controls, leave datapath as-is.
            valid_d      = 1'b0;
            ctrl_d       = '0;
            jal_d        = 1'b0;
            eq_d         = 1'b0;
            mem_signed_d = 1'b0;
            mem_size_d   = '0;
            if (!flush_i && stall_cnt_q != '1) begin
                stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
            end
        end else if (!ex_hold_i) begin
            valid_d      = id_valid_i;
            ctrl_d       = id_valid_i ? id_ctrl_i       : '0;
            jal_d        = id_valid_i & id_jal_i;
            eq_d         = id_valid_i & id_eq_i;
            mem_signed_d = id_valid_i & id_mem_signed_i;
            mem_size_d   = id_valid_i ? id_mem_size_i   : 2'b00;
            pc4_d        = id_pc4_i;
            rs_data_d    = id_rs_data_i;
            rt_data_d    = id_rt_data_i;
            imm_d        = id_imm_i;
            rs_d         = id_rs_i;
            rt_d         = id_rt_i;
            rd_d         = id_rd_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            ctrl_q       <= '0;
            jal_q        <= 1'b0;
            eq_q         <= 1'b0;
            mem_signed_q <= 1'b0;
            mem_size_q   <= '0;
            pc4_q        <= '0;
            rs_data_q    <= '0;
            rt_data_q    <= '0;
            imm_q        <= '0;
            rs_q         <= '0;
            rt_q         <= '0;
            rd_q         <= '0;
            stall_cnt_q  <= '0;
        end else begin
            valid_q      <= valid_d;
            ctrl_q       <= ctrl_d;
            jal_q        <= jal_d;
            eq_q         <= eq_d;
            mem_signed_q <= mem_signed_d;
            mem_size_q   <= mem_size_d;
            pc4_q        <= pc4_d;
            rs_data_q    <= rs_data_d;
            rt_data_q    <= rt_data_d;
            imm_q        <= imm_d;
            rs_q         <= rs_d;
            rt_q         <= rt_d;
            rd_q         <= rd_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign ex_valid_o      = valid_q;
    assign ex_ctrl_o       = ctrl_q;
    assign ex_jal_o        = jal_q;
    assign ex_eq_o         = eq_q;
    assign ex_mem_signed_o = mem_signed_q;
    assign ex_mem_size_o   = mem_size_q;
    assign ex_pc4_o        = pc4_q;
    assign ex_rs_data_o    = rs_data_q;
    assign ex_rt_data_o    = rt_data_q;
    assign ex_imm_o        = imm_q;
    assign ex_rs_o         = rs_q;
    assign ex_rt_o         = rt_q;
    assign ex_rd_o         = rd_q;
    assign stall_cnt_o     = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_reg_r0.sv
// Directed bench for id_ex_reg_r0: capture, load-use bubble, flush, hold,
// async reset and counter saturation (second instance with a 2-bit counter).
module tb_id_ex_reg_r0;

    localparam logic [14:0] C_ADDI = 15'h4110; // ALUop 0x20, regWrite, ALUsrc
    localparam logic [14:0] C_ADD  = 15'h4180; // ALUop 0x20, regWrite, regDest
    localparam logic [14:0] C_LW   = 15'h4752; // ALUop 0x23, regWrite, memToReg, ALUsrc, memRead
    localparam logic [14:0] C_SW   = 15'h5611; // ALUop 0x2b, ALUsrc, memWrite

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_jal, id_eq, id_mem_signed, flush, ex_hold;
    logic [14:0] id_ctrl;
    logic [1:0]  id_mem_size;
    logic [31:0] id_pc4, id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;

    logic        ex_valid, ex_jal, ex_eq, ex_mem_signed, hazard;
    logic [14:0] ex_ctrl;
    logic [1:0]  ex_mem_size;
    logic [31:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [15:0] stall_cnt;

    logic        s_valid, s_jal, s_eq, s_mem_signed, s_hazard;
    logic [14:0] s_ctrl;
    logic [1:0]  s_mem_size;
    logic [31:0] s_pc4, s_rs_data, s_rt_data, s_imm;
    logic [4:0]  s_rs, s_rt, s_rd;
    logic [1:0]  s_cnt;

    int n_tot = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    id_ex_reg_r0 dut (
        .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid), .id_ctrl_i(id_ctrl),
        .id_jal_i(id_jal), .id_eq_i(id_eq), .id_mem_signed_i(id_mem_signed),
        .id_mem_size_i(id_mem_size), .id_pc4_i(id_pc4), .id_rs_data_i(id_rs_data),
        .id_rt_data_i(id_rt_data), .id_imm_i(id_imm), .id_rs_i(id_rs), .id_rt_i(id_rt),
        .id_rd_i(id_rd), .flush_i(flush), .ex_hold_i(ex_hold), .ex_valid_o(ex_valid),
        .ex_ctrl_o(ex_ctrl), .ex_jal_o(ex_jal), .ex_eq_o(ex_eq),
        .ex_mem_signed_o(ex_mem_signed), .ex_mem_size_o(ex_mem_size), .ex_pc4_o(ex_pc4),
        .ex_rs_data_o(ex_rs_data), .ex_rt_data_o(ex_rt_data), .ex_imm_o(ex_imm),
        .ex_rs_o(ex_rs), .ex_rt_o(ex_rt), .ex_rd_o(ex_rd),
        .hazard_stall_c_o(hazard), .stall_cnt_o(stall_cnt)
    );

    id_ex_reg_r0 #(.CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid), .id_ctrl_i(id_ctrl),
        .id_jal_i(id_jal), .id_eq_i(id_eq), .id_mem_signed_i(id_mem_signed),
        .id_mem_size_i(id_mem_size), .id_pc4_i(id_pc4), .id_rs_data_i(id_rs_data),
        .id_rt_data_i(id_rt_data), .id_imm_i(id_imm), .id_rs_i(id_rs), .id_rt_i(id_rt),
        .id_rd_i(id_rd), .flush_i(flush), .ex_hold_i(ex_hold), .ex_valid_o(s_valid),
        .ex_ctrl_o(s_ctrl), .ex_jal_o(s_jal), .ex_eq_o(s_eq),
        .ex_mem_signed_o(s_mem_signed), .ex_mem_size_o(s_mem_size), .ex_pc4_o(s_pc4),
        .ex_rs_data_o(s_rs_data), .ex_rt_data_o(s_rt_data), .ex_imm_o(s_imm),
        .ex_rs_o(s_rs), .ex_rt_o(s_rt), .ex_rd_o(s_rd),
        .hazard_stall_c_o(s_hazard), .stall_cnt_o(s_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [14:0] c, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [31:0] imm);
        id_valid   = 1'b1;
        id_ctrl    = c;
        id_rs      = rs;
        id_rt      = rt;
        id_rd      = rd;
        id_imm     = imm;
        id_pc4     = 32'h100 + 32'(rd);
        id_rs_data = 32'hA000 + 32'(rs);
        id_rt_data = 32'hB000 + 32'(rt);
    endtask

    initial begin
        rst_n = 1'b0;
        id_valid = 1'b0; id_ctrl = '0; id_jal = 1'b0; id_eq = 1'b0; id_mem_signed = 1'b0;
        id_mem_size = 2'b00; id_pc4 = '0; id_rs_data = '0; id_rt_data = '0; id_imm = '0;
        id_rs = '0; id_rt = '0; id_rd = '0; flush = 1'b0; ex_hold = 1'b0;
        step(); step();
        chk("rst_valid", 64'(ex_valid), 64'd0);
        chk("rst_cnt", 64'(stall_cnt), 64'd0);
        rst_n = 1'b1;

        // addi capture, with extra controls set
        set_id(C_ADDI, 5'd1, 5'd2, 5'd0, 32'h0000_0005);
        id_jal = 1'b1; id_eq = 1'b1; id_mem_signed = 1'b1; id_mem_size = 2'b10;
        #1 chk("addi_hazard", 64'(hazard), 64'd0);
        step();
        chk("addi_valid", 64'(ex_valid), 64'd1);
        chk("addi_ctrl", 64'(ex_ctrl), 64'(C_ADDI));
        chk("addi_imm", 64'(ex_imm), 64'h5);
        chk("addi_rt", 64'(ex_rt), 64'd2);
        chk("addi_pc4", 64'(ex_pc4), 64'h100);
        chk("addi_rsd", 64'(ex_rs_data), 64'hA001);
        chk("addi_misc", 64'({ex_jal, ex_eq, ex_mem_signed, ex_mem_size}), 64'b11110);
        id_jal = 1'b0; id_eq = 1'b0; id_mem_signed = 1'b0; id_mem_size = 2'b00;

        // async reset between edges
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(ex_valid), 64'd0);
        chk("arst_ctrl", 64'(ex_ctrl), 64'd0);
        chk("arst_imm", 64'(ex_imm), 64'd0);
        chk("arst_misc", 64'({ex_jal, ex_eq, ex_mem_size}), 64'd0);
        rst_n = 1'b1;

        // load-use on rs
        set_id(C_LW, 5'd29, 5'd8, 5'd0, 32'h4);
        step();
        chk("lw_valid", 64'(ex_valid), 64'd1);
        set_id(C_ADD, 5'd8, 5'd9, 5'd10, 32'h0);
        #1 chk("lu_hazard", 64'(hazard), 64'd1);
        step();
        chk("lu_bub_valid", 64'(ex_valid), 64'd0);
        chk("lu_bub_ctrl", 64'(ex_ctrl), 64'd0);
        chk("lu_bub_rt_hold", 64'(ex_rt), 64'd8);
        chk("lu_cnt", 64'(stall_cnt), 64'd1);
        chk("lu_hazard_off", 64'(hazard), 64'd0);
        step();
        chk("lu_add_ctrl", 64'(ex_ctrl), 64'(C_ADD));
        chk("lu_add_rd", 64'(ex_rd), 64'd10);

        // lw into $0 never stalls
        set_id(C_LW, 5'd29, 5'd0, 5'd0, 32'h4);
        step();
        set_id(C_ADD, 5'd0, 5'd9, 5'd11, 32'h0);
        #1 chk("r0_hazard", 64'(hazard), 64'd0);
        step();
        chk("r0_ctrl", 64'(ex_ctrl), 64'(C_ADD));
        chk("r0_cnt", 64'(stall_cnt), 64'd1);

        // load-use coinciding with flush
        set_id(C_LW, 5'd29, 5'd8, 5'd0, 32'h4);
        step();
        set_id(C_ADD, 5'd8, 5'd9, 5'd12, 32'h0);
        flush = 1'b1;
        #1 chk("fl_hazard", 64'(hazard), 64'd0);
        step();
        flush = 1'b0;
        chk("fl_valid", 64'(ex_valid), 64'd0);
        chk("fl_ctrl", 64'(ex_ctrl), 64'd0);
        chk("fl_cnt", 64'(stall_cnt), 64'd1);

        // store data dependency via rt
        set_id(C_LW, 5'd29, 5'd8, 5'd0, 32'h4);
        step();
        set_id(C_SW, 5'd3, 5'd8, 5'd0, 32'h8);
        #1 chk("sw_hazard", 64'(hazard), 64'd1);
        step();
        chk("sw_cnt", 64'(stall_cnt), 64'd2);
        step();
        chk("sw_ctrl", 64'(ex_ctrl), 64'(C_SW));

        // immediate-form consumer of rt does not stall
        set_id(C_LW, 5'd29, 5'd8, 5'd0, 32'h4);
        step();
        set_id(C_ADDI, 5'd3, 5'd8, 5'd0, 32'h7);
        #1 chk("addi_rt_hazard", 64'(hazard), 64'd0);
        step();
        chk("addi_rt_ctrl", 64'(ex_ctrl), 64'(C_ADDI));

        // downstream hold for 3 cycles
        set_id(C_ADD, 5'd4, 5'd5, 5'd6, 32'h99);
        ex_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("hold_hazard", 64'(hazard), 64'd1);
            step();
            chk("hold_ctrl", 64'(ex_ctrl), 64'(C_ADDI));
            chk("hold_imm", 64'(ex_imm), 64'h7);
        end
        flush = 1'b1;
        #1 chk("hold_flush_hazard", 64'(hazard), 64'd0);
        flush = 1'b0;
        ex_hold = 1'b0;
        step();
        chk("unhold_ctrl", 64'(ex_ctrl), 64'(C_ADD));

        // invalid ID instruction: controls zeroed, datapath captured
        set_id(C_LW, 5'd7, 5'd8, 5'd9, 32'h55);
        id_valid = 1'b0;
        step();
        chk("inv_valid", 64'(ex_valid), 64'd0);
        chk("inv_ctrl", 64'(ex_ctrl), 64'd0);
        chk("inv_imm", 64'(ex_imm), 64'h55);

        // five more hazards: wide counter reaches 7, 2-bit counter saturates
        for (int i = 0; i < 5; i++) begin
            set_id(C_LW, 5'd29, 5'd8, 5'd0, 32'h4);
            step();
            set_id(C_ADD, 5'd8, 5'd9, 5'd10, 32'h0);
            step();
        end
        chk("sat_wide_cnt", 64'(stall_cnt), 64'd7);
        chk("sat_small_cnt", 64'(s_cnt), 64'd3);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
